l2_flush_ctrl: RTL and testbench

// - Owns the L2 flush-walk state: ongoing_flush flag, flush_set/flush_way cursors, flush mode, and writeback count.
// - Driven by the L2 input decoder's flush strobes and by datapath way-completion strobes.
// - Feeds flush_set/flush_way/ongoing_flush back to the decoder.
// - Returns a valid/ready flush-completion response to the CPU side.

---
 rtl/l2_flush_pkg.sv | 23 ++
 rtl/l2_flush_sat_cnt.sv | 25 ++
 rtl/l2_flush_ctrl.sv | 123 ++++++++++++
 tb/tb_l2_flush_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_flush_pkg.sv
// Shared types and constants for the L2 flush-walk controller.
package l2_flush_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSHING = 2'd1,
    RSP      = 2'd2
  } flush_state_t;

  localparam logic FLUSH_MODE_WBINV = 1'b0;
  localparam logic FLUSH_MODE_WB    = 1'b1;

  localparam int L2_SETS = 256;
  localparam int L2_WAYS = 8;

  // One extra bit so the "walk finished" / "set finished" terminal value fits.
  localparam int L2_SET_W = $clog2(L2_SETS) + 1;
  localparam int L2_WAY_W = $clog2(L2_WAYS) + 1;

  typedef logic [L2_SET_W-1:0] l2_set_t;
  typedef logic [L2_WAY_W-1:0] l2_way_t;

endpackage

// File: rtl/l2_flush_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module l2_flush_sat_cnt
  import l2_flush_pkg::*;
#(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/l2_flush_ctrl.sv
// L2 flush-walk controller: owns the walk cursors, mode, writeback count and
// the valid/ready completion response back to the CPU side.
module l2_flush_ctrl
  import l2_flush_pkg::*;
#(
  parameter int SETS    = 256,
  parameter int WAYS    = 8,
  parameter int WBCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_ongoing_flush,
  input  logic                      flush_mode_in,
  input  logic                      incr_flush_set,
  input  logic                      clr_flush_set,
  input  logic                      clr_flush_way,
  input  logic                      flush_done,
  input  logic                      way_done,
  input  logic                      wb_issued,
  output logic                      ongoing_flush,
  output logic [$clog2(SETS):0]     flush_set,
  output logic [$clog2(WAYS):0]     flush_way,
  output logic                      flush_mode,
  output logic                      flush_accept_ok,
  output logic                      flush_rsp_valid,
  input  logic                      flush_rsp_ready,
  output logic [WBCNT_W-1:0]        flush_rsp_wb_cnt,
  output logic                      err_overlap
);

  localparam int SET_W = $clog2(SETS) + 1;
  localparam int WAY_W = $clog2(WAYS) + 1;

  flush_state_t state;
  logic         in_idle;
  logic         in_flush;
  logic         start;

  assign in_idle  = (state == IDLE);
  assign in_flush = (state == FLUSHING);
  assign start    = in_idle && set_ongoing_flush;

  l2_flush_sat_cnt #(
    .W   (SET_W),
    .MAX (SET_W'(SETS))
  ) u_set_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_flush && incr_flush_set),
    .clr (start || (in_flush && clr_flush_set)),
    .cnt (flush_set)
  );

  l2_flush_sat_cnt #(
    .W   (WAY_W),
    .MAX (WAY_W'(WAYS))
  ) u_way_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_flush && way_done),
    .clr (start || (in_flush && clr_flush_way)),
    .cnt (flush_way)
  );

  // The wb counter only moves in FLUSHING and is cleared on start, so it is
  // frozen throughout RSP and serves directly as the response payload. A
  // writeback coinciding with flush_done lands on the same edge.
  l2_flush_sat_cnt #(
    .W   (WBCNT_W),
    .MAX ('1)
  ) u_wb_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_flush && wb_issued),
    .clr (start),
    .cnt (flush_rsp_wb_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      ongoing_flush   <= 1'b0;
      flush_mode      <= FLUSH_MODE_WBINV;
      flush_accept_ok <= 1'b0;
      flush_rsp_valid <= 1'b0;
      err_overlap     <= 1'b0;
    end else begin
      if (set_ongoing_flush && !in_idle) begin
        err_overlap <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (set_ongoing_flush) begin
            state           <= FLUSHING;
            flush_mode      <= flush_mode_in;
            ongoing_flush   <= 1'b1;
            flush_accept_ok <= 1'b0;
          end else begin
            flush_accept_ok <= 1'b1;
          end
        end
        FLUSHING: begin
          if (flush_done) begin
            state           <= RSP;
            ongoing_flush   <= 1'b0;
            flush_rsp_valid <= 1'b1;
          end
        end
        RSP: begin
          if (flush_rsp_ready) begin
            state           <= IDLE;
            flush_rsp_valid <= 1'b0;
            flush_accept_ok <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Directed bench for l2_flush_ctrl with SETS=4, WAYS=2, WBCNT_W=4.
module tb_l2_flush_ctrl;

  localparam int SETS    = 4;
  localparam int WAYS    = 2;
  localparam int WBCNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  set_ongoing_flush;
  logic                  flush_mode_in;
  logic                  incr_flush_set;
  logic                  clr_flush_set;
  logic                  clr_flush_way;
  logic                  flush_done;
  logic                  way_done;
  logic                  wb_issued;
  logic                  ongoing_flush;
  logic [2:0]            flush_set;
  logic [1:0]            flush_way;
  logic                  flush_mode;
  logic                  flush_accept_ok;
  logic                  flush_rsp_valid;
  logic                  flush_rsp_ready;
  logic [WBCNT_W-1:0]    flush_rsp_wb_cnt;
  logic                  err_overlap;

  int n_cmp = 0;
  int n_err = 0;

  l2_flush_ctrl #(
    .SETS    (SETS),
    .WAYS    (WAYS),
    .WBCNT_W (WBCNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .set_ongoing_flush (set_ongoing_flush),
    .flush_mode_in     (flush_mode_in),
    .incr_flush_set    (incr_flush_set),
    .clr_flush_set     (clr_flush_set),
    .clr_flush_way     (clr_flush_way),
    .flush_done        (flush_done),
    .way_done          (way_done),
    .wb_issued         (wb_issued),
    .ongoing_flush     (ongoing_flush),
    .flush_set         (flush_set),
    .flush_way         (flush_way),
    .flush_mode        (flush_mode),
    .flush_accept_ok   (flush_accept_ok),
    .flush_rsp_valid   (flush_rsp_valid),
    .flush_rsp_ready   (flush_rsp_ready),
    .flush_rsp_wb_cnt  (flush_rsp_wb_cnt),
    .err_overlap       (err_overlap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample point is 1ns after the edge; strobes are one-shot.
  task automatic tick();
    @(posedge clk);
    #1;
    set_ongoing_flush = 1'b0;
    incr_flush_set    = 1'b0;
    clr_flush_set     = 1'b0;
    clr_flush_way     = 1'b0;
    flush_done        = 1'b0;
    way_done          = 1'b0;
    wb_issued         = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    set_ongoing_flush = 1'b0;
    flush_mode_in     = 1'b0;
    incr_flush_set    = 1'b0;
    clr_flush_set     = 1'b0;
    clr_flush_way     = 1'b0;
    flush_done        = 1'b0;
    way_done          = 1'b0;
    wb_issued         = 1'b0;
    flush_rsp_ready   = 1'b0;

    tick();
    tick();
    check("rst_ongoing", ongoing_flush, 0);
    check("rst_set", flush_set, 0);
    check("rst_way", flush_way, 0);
    check("rst_mode", flush_mode, 0);
    check("rst_accept", flush_accept_ok, 0);
    check("rst_valid", flush_rsp_valid, 0);
    check("rst_wbcnt", flush_rsp_wb_cnt, 0);
    check("rst_err", err_overlap, 0);

    rst = 1'b1;
    tick();
    check("idle_accept", flush_accept_ok, 1);
    check("idle_ongoing", ongoing_flush, 0);

    // Start a writeback-only flush.
    set_ongoing_flush = 1'b1;
    flush_mode_in     = 1'b1;
    tick();
    check("start_ongoing", ongoing_flush, 1);
    check("start_mode", flush_mode, 1);
    check("start_set", flush_set, 0);
    check("start_way", flush_way, 0);
    check("start_accept", flush_accept_ok, 0);

    // Full walk; writebacks on sets 0 and 1, third one rides with flush_done.
    for (int s = 0; s < SETS; s++) begin
      way_done  = 1'b1;
      wb_issued = (s < 2);
      tick();
      way_done = 1'b1;
      tick();
      check("walk_way", flush_way, 2);
      incr_flush_set = 1'b1;
      clr_flush_way  = 1'b1;
      tick();
      check("walk_set", flush_set, s + 1);
      check("walk_way_clr", flush_way, 0);
    end
    check("walk_wb_pre", flush_rsp_wb_cnt, 2);
    flush_done = 1'b1;
    wb_issued  = 1'b1;
    tick();
    check("done_valid", flush_rsp_valid, 1);
    check("done_wbcnt", flush_rsp_wb_cnt, 3);
    check("done_ongoing", ongoing_flush, 0);
    check("done_set", flush_set, 4);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", flush_rsp_valid, 1);
      check("stall_wbcnt", flush_rsp_wb_cnt, 3);
    end
    flush_rsp_ready = 1'b1;
    tick();
    flush_rsp_ready = 1'b0;
    check("hs_valid", flush_rsp_valid, 0);
    check("hs_accept", flush_accept_ok, 1);
    check("hs_mode_hold", flush_mode, 1);

    // Walk strobes in IDLE must be ignored.
    way_done       = 1'b1;
    incr_flush_set = 1'b1;
    wb_issued      = 1'b1;
    flush_done     = 1'b1;
    clr_flush_set  = 1'b1;
    tick();
    check("ign_set", flush_set, 4);
    check("ign_way", flush_way, 0);
    check("ign_wbcnt", flush_rsp_wb_cnt, 3);
    check("ign_valid", flush_rsp_valid, 0);
    check("ign_ongoing", ongoing_flush, 0);

    // Second flush: saturation and collisions.
    set_ongoing_flush = 1'b1;
    flush_mode_in     = 1'b0;
    tick();
    check("s2_mode", flush_mode, 0);
    check("s2_wbclr", flush_rsp_wb_cnt, 0);
    check("s2_setclr", flush_set, 0);
    for (int i = 0; i < 3; i++) begin
      way_done = 1'b1;
      tick();
    end
    check("sat_way", flush_way, 2);
    for (int i = 0; i < 20; i++) begin
      wb_issued = 1'b1;
      tick();
    end
    check("sat_wb", flush_rsp_wb_cnt, 15);
    way_done      = 1'b1;
    clr_flush_way = 1'b1;
    tick();
    check("col_way", flush_way, 0);
    incr_flush_set = 1'b1;
    tick();
    incr_flush_set = 1'b1;
    clr_flush_set  = 1'b1;
    tick();
    check("col_set", flush_set, 0);
    incr_flush_set = 1'b1;
    way_done       = 1'b1;
    tick();
    check("pre_ovl_set", flush_set, 1);
    check("pre_ovl_way", flush_way, 1);
    set_ongoing_flush = 1'b1;
    flush_mode_in     = 1'b1;
    tick();
    check("ovl_err", err_overlap, 1);
    check("ovl_set", flush_set, 1);
    check("ovl_way", flush_way, 1);
    check("ovl_mode", flush_mode, 0);
    check("ovl_ongoing", ongoing_flush, 1);
    incr_flush_set = 1'b1;
    clr_flush_way  = 1'b1;
    tick();
    check("step_set", flush_set, 2);
    check("step_way", flush_way, 0);
    flush_done = 1'b1;
    tick();
    check("s2_valid", flush_rsp_valid, 1);
    check("s2_wbcnt", flush_rsp_wb_cnt, 15);
    flush_rsp_ready = 1'b1;
    tick();
    flush_rsp_ready = 1'b0;
    check("s2_hs_valid", flush_rsp_valid, 0);

    // Third flush aborted by reset mid-walk.
    set_ongoing_flush = 1'b1;
    tick();
    incr_flush_set = 1'b1;
    tick();
    incr_flush_set = 1'b1;
    tick();
    check("ab_set", flush_set, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("ab_ongoing", ongoing_flush, 0);
    check("ab_set_clr", flush_set, 0);
    check("ab_err_clr", err_overlap, 0);
    check("ab_valid", flush_rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      flush_rsp_ready = 1'b1;
      tick();
      check("ab_no_rsp", flush_rsp_valid, 0);
      check("ab_idle", ongoing_flush, 0);
    end
    flush_rsp_ready = 1'b0;
    check("ab_accept", flush_accept_ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
